// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for the memory access unit.
//   state_t  : sequencer states (IDLE, RD, RD_WAIT, WR)
//   src_t    : which master owns the in-flight access (fetch or data)
//   F3_*     : RV32I load/store width encodings
//   f3_legal : whether a funct3 code is valid for a load or a store
`timescale 1ns/1ps
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} state_t;
  typedef enum logic {SRC_I, SRC_D} src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling between a 32-bit memory word and
// the core's right-aligned data.
//   i_word   : word read from memory
//   i_lane   : byte address bits [1:0]
//   i_funct3 : access width/sign code
//   i_wdata  : right-aligned store data
//   o_load   : extracted and sign/zero-extended load result
//   o_merge  : i_word with the store data inserted in the addressed lane
`timescale 1ns/1ps
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase

    // Untouched lanes keep the old word so the write-back preserves them.
    o_merge = i_word;
    case (i_funct3)
      F3_B: o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: arbitrates instruction fetch and load/store onto a single
// port word memory with a one-cycle registered read.
//   Clk, Reset            : clock, asynchronous active-high reset
//   i_req/i_addr          : fetch request (level) and byte address
//   i_done/i_rdata/i_err  : fetch completion pulse, word, error
//   d_req/d_we/d_funct3   : data request (level), store flag, width code
//   d_addr/d_wdata        : data byte address, right-aligned store data
//   d_done/d_rdata/d_err  : data completion pulse, extended load, error
//   mem_*                 : memory port (word address, write data, enables)
`timescale 1ns/1ps
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [31:0]       mem_readout
);

  state_t            r_state;
  src_t              r_src;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_mem_data;
  logic              r_i_done, r_i_err, r_d_done, r_d_err;
  logic [31:0]       r_i_rdata, r_d_rdata;

  logic              w_req;
  logic [31:0]       w_addr;
  logic              w_we;
  logic [2:0]        w_f3;
  logic              w_err;
  logic [31:0]       w_load, w_merge;

  // Request selection and accept-time error check; data wins over fetch.
  // A fetch is treated as a word load so the same checks and datapath apply.
  always_comb begin
    w_req  = d_req | i_req;
    w_addr = d_req ? d_addr : i_addr;
    w_we   = d_req & d_we;
    w_f3   = d_req ? d_funct3 : F3_W;
    w_err  = 1'b0;
    if (((w_f3 == F3_H) || (w_f3 == F3_HU)) && w_addr[0])  w_err = 1'b1;
    if ((w_f3 == F3_W) && (w_addr[1:0] != 2'b00))          w_err = 1'b1;
    if (|w_addr[31:ADDR_W+2])                               w_err = 1'b1;
    if (!f3_legal(w_we, w_f3))                              w_err = 1'b1;
  end

  lsu_align u_align (
    .i_word   (mem_readout),
    .i_lane   (r_addr[1:0]),
    .i_funct3 (r_f3),
    .i_wdata  (r_mem_data),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_src      <= SRC_I;
      r_we       <= 1'b0;
      r_f3       <= 3'd0;
      r_addr     <= '0;
      r_mem_data <= 32'd0;
      r_i_done   <= 1'b0;
      r_i_err    <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_done   <= 1'b0;
      r_d_err    <= 1'b0;
      r_d_rdata  <= 32'd0;
    end else begin
      // Completion outputs are one-cycle pulses.
      r_i_done  <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= 32'd0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= 32'd0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_src      <= d_req ? SRC_D : SRC_I;
            r_we       <= w_we;
            r_f3       <= w_f3;
            r_addr     <= w_addr[ADDR_W+1:0];
            // Store data waits here; a sub-word store overwrites it with the merge.
            r_mem_data <= d_wdata;
            if (w_err) begin
              if (d_req) begin
                r_d_done <= 1'b1;
                r_d_err  <= 1'b1;
              end else begin
                r_i_done <= 1'b1;
                r_i_err  <= 1'b1;
              end
            end else if (w_we && (w_f3 == F3_W)) begin
              r_state <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: r_state <= RD_WAIT;
        RD_WAIT: begin
          if (r_we) begin
            r_mem_data <= w_merge;
            r_state    <= WR;
          end else begin
            if (r_src == SRC_D) begin
              r_d_done  <= 1'b1;
              r_d_rdata <= w_load;
            end else begin
              r_i_done  <= 1'b1;
              r_i_rdata <= w_load;
            end
            r_state <= IDLE;
          end
        end
        WR: begin
          r_d_done <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rden    = (r_state == RD);
  assign mem_wren    = (r_state == WR);
  assign mem_address = r_addr[ADDR_W+1:2];
  assign mem_data    = r_mem_data;

  assign i_done  = r_i_done;
  assign i_err   = r_i_err;
  assign i_rdata = r_i_rdata;
  assign d_done  = r_d_done;
  assign d_err   = r_d_err;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int ADDR_W = 10;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = 32'd0;
  logic              i_done;
  logic [31:0]       i_rdata;
  logic              i_err;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [2:0]        d_funct3 = 3'd0;
  logic [31:0]       d_addr = 32'd0;
  logic [31:0]       d_wdata = 32'd0;
  logic              d_done;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data;
  logic              mem_rden;
  logic              mem_wren;
  logic [31:0]       mem_readout = 32'd0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_readout(mem_readout)
  );

  always #5 Clk = ~Clk;

  // Word memory with one-cycle registered read.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge Clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    if (mem_rden) mem_readout <= mem[mem_address];
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int d_done_cnt = 0;
  logic [31:0] last_wr_data = 32'd0;
  logic [32:0] d_q [$];
  logic [32:0] i_q [$];

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    logic [32:0] exp_v;
    if (mem_rden) rd_cnt++;
    if (mem_wren) begin
      wr_cnt++;
      last_wr_data = mem_data;
    end
    if (mem_rden || mem_wren || i_done || d_done) begin
      total_cnt++;
      if (mem_rden && mem_wren)
        $display("FAIL rden_wren_excl: rden=%0b wren=%0b, required not both", mem_rden, mem_wren);
      else if (i_done && d_done)
        $display("FAIL done_excl: i_done=%0b d_done=%0b, required not both", i_done, d_done);
      else pass_cnt++;
    end
    if (d_done) begin
      d_done_cnt++;
      total_cnt++;
      if (d_q.size() == 0) begin
        $display("FAIL d_sb_unexpected: d_done with rdata=%h err=%0b, none expected", d_rdata, d_err);
      end else begin
        exp_v = d_q.pop_front();
        if ({d_err, d_rdata} !== exp_v)
          $display("FAIL d_sb: err=%0b rdata=%h, required err=%0b rdata=%h", d_err, d_rdata, exp_v[32], exp_v[31:0]);
        else pass_cnt++;
      end
    end
    if (i_done) begin
      total_cnt++;
      if (i_q.size() == 0) begin
        $display("FAIL i_sb_unexpected: i_done with rdata=%h err=%0b, none expected", i_rdata, i_err);
      end else begin
        exp_v = i_q.pop_front();
        if ({i_err, i_rdata} !== exp_v)
          $display("FAIL i_sb: err=%0b rdata=%h, required err=%0b rdata=%h", i_err, i_rdata, exp_v[32], exp_v[31:0]);
        else pass_cnt++;
      end
    end
  end

  // Drives one data access and waits (bounded) for d_done.
  task automatic run_data(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                          output int lat, output int nrd, output int nwr);
    @(negedge Clk);
    d_q.push_back({exp_err, exp_rdata});
    d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    rd_cnt = 0; wr_cnt = 0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (d_done) begin
        lat = c;
        break;
      end
    end
    d_req = 1'b0;
    nrd = rd_cnt;
    nwr = wr_cnt;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({mem_rden, mem_wren, mem_address, mem_data} !== '0)
      $display("FAIL reset_mem: rden=%0b wren=%0b addr=%h data=%h, required all 0", mem_rden, mem_wren, mem_address, mem_data);
    else pass_cnt++;
    total_cnt++;
    if ({i_done, i_err, i_rdata, d_done, d_err, d_rdata} !== '0)
      $display("FAIL reset_core: i_done=%0b d_done=%0b i_rdata=%h d_rdata=%h, required all 0", i_done, d_done, i_rdata, d_rdata);
    else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_load_word();
    int lat, nrd, nwr;
    run_data(1'b0, 3'b010, 32'h4, 32'd0, 32'h876543A1, 1'b0, lat, nrd, nwr);
    total_cnt++;
    if (lat !== 3) $display("FAIL lw_latency: %0d cycles, required 3", lat);
    else pass_cnt++;
    total_cnt++;
    if (nrd !== 1 || nwr !== 0) $display("FAIL lw_mem_cycles: rden=%0d wren=%0d, required 1 and 0", nrd, nwr);
    else pass_cnt++;
  endtask

  task automatic test_ext_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ads [4] = '{32'h4, 32'h7, 32'h6, 32'h4};
    logic [31:0] exs [4] = '{32'hFFFFFFA1, 32'h00000087, 32'hFFFF8765, 32'h000043A1};
    int lat, nrd, nwr;
    for (int k = 0; k < 4; k++) begin
      run_data(1'b0, f3s[k], ads[k], 32'd0, exs[k], 1'b0, lat, nrd, nwr);
      total_cnt++;
      if (lat !== 3) $display("FAIL ext_latency[%0d]: %0d cycles, required 3", k, lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int d_cyc = -1;
    int i_cyc = -1;
    @(negedge Clk);
    d_q.push_back({1'b0, 32'h876543A1});
    i_q.push_back({1'b0, 32'h00000013});
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h4;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (d_done && d_cyc < 0) begin d_cyc = c; d_req = 1'b0; end
      if (i_done && i_cyc < 0) begin i_cyc = c; i_req = 1'b0; end
      if (d_cyc > 0 && i_cyc > 0) break;
    end
    d_req = 1'b0; i_req = 1'b0;
    total_cnt++;
    if (d_cyc !== 3) $display("FAIL arb_d_first: d_done at cycle %0d, required 3", d_cyc);
    else pass_cnt++;
    total_cnt++;
    if (i_cyc !== 6) $display("FAIL arb_i_after: i_done at cycle %0d, required 6", i_cyc);
    else pass_cnt++;
  endtask

  task automatic test_stores();
    int lat, nrd, nwr;
    run_data(1'b1, 3'b000, 32'h5, 32'h123456FF, 32'd0, 1'b0, lat, nrd, nwr);
    total_cnt++;
    if (lat !== 4) $display("FAIL sb_latency: %0d cycles, required 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (nrd !== 1 || nwr !== 1) $display("FAIL sb_mem_cycles: rden=%0d wren=%0d, required 1 and 1", nrd, nwr);
    else pass_cnt++;
    total_cnt++;
    if (last_wr_data !== 32'h8765FFA1) $display("FAIL sb_merge: mem_data=%h, required 8765ffa1", last_wr_data);
    else pass_cnt++;
    run_data(1'b0, 3'b010, 32'h4, 32'd0, 32'h8765FFA1, 1'b0, lat, nrd, nwr);
    run_data(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 32'd0, 1'b0, lat, nrd, nwr);
    total_cnt++;
    if (lat !== 2) $display("FAIL sw_latency: %0d cycles, required 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (nrd !== 0 || nwr !== 1 || last_wr_data !== 32'hDEADBEEF)
      $display("FAIL sw_mem_cycles: rden=%0d wren=%0d data=%h, required 0, 1, deadbeef", nrd, nwr, last_wr_data);
    else pass_cnt++;
    run_data(1'b0, 3'b010, 32'h8, 32'd0, 32'hDEADBEEF, 1'b0, lat, nrd, nwr);
  endtask

  task automatic test_errors();
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] ads [4] = '{32'h6, 32'h3, 32'h1000, 32'h4};
    int lat, nrd, nwr;
    for (int k = 0; k < 4; k++) begin
      run_data(wes[k], f3s[k], ads[k], 32'hA5A5A5A5, 32'd0, 1'b1, lat, nrd, nwr);
      total_cnt++;
      if (lat !== 1 || nrd !== 0 || nwr !== 0)
        $display("FAIL err_case[%0d]: latency=%0d rden=%0d wren=%0d, required 1, 0, 0", k, lat, nrd, nwr);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_op();
    int done_before;
    @(negedge Clk);
    d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'b000; d_addr = 32'h5; d_wdata = 32'h000000AA;
    wr_cnt = 0;
    done_before = d_done_cnt;
    @(negedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    total_cnt++;
    if ({mem_rden, mem_wren, mem_address, mem_data, d_done, d_err, d_rdata} !== '0)
      $display("FAIL rst_async: rden=%0b wren=%0b addr=%h data=%h d_done=%0b, required all 0",
               mem_rden, mem_wren, mem_address, mem_data, d_done);
    else pass_cnt++;
    d_req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    total_cnt++;
    if (wr_cnt !== 0 || d_done_cnt !== done_before)
      $display("FAIL rst_abandon: wren cycles=%0d done pulses=%0d, required 0 and 0", wr_cnt, d_done_cnt - done_before);
    else pass_cnt++;
    total_cnt++;
    if (mem[1] !== 32'h8765FFA1) $display("FAIL rst_mem_word: word1=%h, required 8765ffa1", mem[1]);
    else pass_cnt++;
  endtask

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'd0;
    mem[0] = 32'h00000013;
    mem[1] = 32'h876543A1;
    test_reset();
    test_load_word();
    test_ext_loads();
    test_back_to_back();
    test_stores();
    test_errors();
    test_reset_mid_op();
    total_cnt++;
    if (d_q.size() != 0 || i_q.size() != 0)
      $display("FAIL sb_drain: %0d data and %0d fetch results never completed", d_q.size(), i_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
